// File: rtl/vga_timing_checker.sv
// vga_timing_checker: passive monitor for hs/vs sync timing.
// Once armed with en, it waits for the first vs assertion, then measures line period, hs width,
// lines per frame and vs width for N_FRAMES frames. It reports sticky error flags, an error event
// count, the last measured line length and frame height, and whether the last completed frame
// was clean.
//
// Ports
//   pclk             pixel clock (only clock)
//   rst_n            asynchronous active-low reset
//   en               1 = run checker, 0 = return to idle
//   hs, vs           sync inputs, synchronous to pclk, active level set by SYNC_POL
//   locked           last completed frame had no errors
//   done             N_FRAMES frames checked; held until en falls
//   frame_cnt        completed frames since arming (saturating)
//   err              sticky flags: [0] line period, [1] hs width, [2] frame lines, [3] vs width
//   err_cnt          error events since arming (saturating)
//   last_line_len    most recent measured line period
//   last_frame_lines most recent measured lines per frame
module vga_timing_checker #(
  parameter int unsigned H_TOTAL  = 1056,
  parameter int unsigned V_TOTAL  = 628,
  parameter int unsigned H_SYNC_W = 128,
  parameter int unsigned V_SYNC_W = 4,
  parameter bit          SYNC_POL = 1'b1,
  parameter int unsigned N_FRAMES = 2,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hs,
  input  logic             vs,
  output logic             locked,
  output logic             done,
  output logic [7:0]       frame_cnt,
  output logic [3:0]       err,
  output logic [7:0]       err_cnt,
  output logic [CNT_W-1:0] last_line_len,
  output logic [CNT_W-1:0] last_frame_lines
);

  typedef enum logic [1:0] {StIdle, StSeek, StMeasure, StDone} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] HTotal = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] VTotal = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] HSyncW = CNT_W'(H_SYNC_W);
  localparam logic [CNT_W-1:0] VSyncW = CNT_W'(V_SYNC_W);

  state_e state_q, state_d;
  logic hs_q, vs_q;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, hw_q, hw_d, lcnt_q, lcnt_d, vw_q, vw_d;
  logic seen_q, seen_d, frame_err_q, frame_err_d, locked_q, locked_d;
  logic [3:0] err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d, frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] last_line_q, last_line_d, last_frame_q, last_frame_d;

  logic hs_act, hs_prev, vs_act, vs_prev;
  logic hs_rise, hs_fall, vs_rise, vs_fall;
  logic meas, arm;
  logic [3:0] ev;
  logic [2:0] ev_n;
  logic [8:0] err_sum, frame_next;

  // Edges compare the live input against the one registered sample.
  assign hs_act  = (hs == SYNC_POL);
  assign hs_prev = (hs_q == SYNC_POL);
  assign vs_act  = (vs == SYNC_POL);
  assign vs_prev = (vs_q == SYNC_POL);
  assign hs_rise = hs_act & ~hs_prev;
  assign hs_fall = ~hs_act & hs_prev;
  assign vs_rise = vs_act & ~vs_prev;
  assign vs_fall = ~vs_act & vs_prev;

  assign meas = (state_q == StMeasure);
  assign arm  = (state_q == StIdle) && en;

  // The first hs edge in MEASURE only starts a line, so line checks need a prior edge.
  assign ev[0] = meas & hs_rise & seen_q & (hcnt_q != HTotal);
  assign ev[1] = meas & hs_fall & (hw_q != HSyncW);
  assign ev[2] = meas & vs_rise & (lcnt_q != VTotal);
  assign ev[3] = meas & vs_fall & (vw_q != VSyncW);
  assign ev_n  = {2'b0, ev[0]} + {2'b0, ev[1]} + {2'b0, ev[2]} + {2'b0, ev[3]};
  assign err_sum    = {1'b0, err_cnt_q} + {6'b0, ev_n};
  assign frame_next = {1'b0, frame_cnt_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (en) state_d = StSeek;
      StSeek:    if (vs_rise) state_d = StMeasure;
      StMeasure: if (vs_rise && (32'(frame_next) >= N_FRAMES)) state_d = StDone;
      StDone:    state_d = StDone;
      default:   state_d = StIdle;
    endcase
    if (!en) state_d = StIdle;
  end

  always_comb begin
    hcnt_d = hcnt_q;
    hw_d   = hw_q;
    lcnt_d = lcnt_q;
    vw_d   = vw_q;
    if (hs_rise) hcnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (hcnt_q != CntMax) hcnt_d = hcnt_q + 1'b1;
    if (hs_rise) hw_d = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (hs_act && hw_q != CntMax) hw_d = hw_q + 1'b1;
    // A coincident hs edge belongs to the new frame and counts as its first line.
    if (vs_rise) lcnt_d = {{(CNT_W-1){1'b0}}, hs_rise};
    else if (hs_rise && lcnt_q != CntMax) lcnt_d = lcnt_q + 1'b1;
    if (vs_rise) vw_d = {{(CNT_W-1){1'b0}}, hs_rise};
    else if (vs_act && hs_rise && vw_q != CntMax) vw_d = vw_q + 1'b1;
  end

  always_comb begin
    err_d        = err_q;
    err_cnt_d    = err_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    locked_d     = locked_q;
    frame_err_d  = frame_err_q;
    last_line_d  = last_line_q;
    last_frame_d = last_frame_q;
    seen_d       = meas & (seen_q | hs_rise);
    if (arm) begin
      err_d       = '0;
      err_cnt_d   = '0;
      frame_cnt_d = '0;
      locked_d    = 1'b0;
      frame_err_d = 1'b0;
    end else begin
      if (|ev) begin
        err_d       = err_q | ev;
        err_cnt_d   = err_sum[8] ? 8'hff : err_sum[7:0];
        locked_d    = 1'b0;
        frame_err_d = 1'b1;
      end
      if (meas && hs_rise && seen_q) last_line_d = hcnt_q;
      // Events flagged on the frame-ending cycle still belong to the frame just ended.
      if (meas && vs_rise) begin
        frame_cnt_d  = frame_next[8] ? 8'hff : frame_next[7:0];
        locked_d     = ~(frame_err_q | (|ev));
        frame_err_d  = 1'b0;
        last_frame_d = lcnt_q;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      hs_q         <= ~SYNC_POL;
      vs_q         <= ~SYNC_POL;
      hcnt_q       <= '0;
      hw_q         <= '0;
      lcnt_q       <= '0;
      vw_q         <= '0;
      seen_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= '0;
      err_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      last_line_q  <= '0;
      last_frame_q <= '0;
    end else begin
      state_q      <= state_d;
      hs_q         <= hs;
      vs_q         <= vs;
      hcnt_q       <= hcnt_d;
      hw_q         <= hw_d;
      lcnt_q       <= lcnt_d;
      vw_q         <= vw_d;
      seen_q       <= seen_d;
      frame_err_q  <= frame_err_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      last_line_q  <= last_line_d;
      last_frame_q <= last_frame_d;
    end
  end

  assign locked           = locked_q & (state_q != StIdle);
  assign done             = (state_q == StDone);
  assign frame_cnt        = frame_cnt_q;
  assign err              = err_q;
  assign err_cnt          = err_cnt_q;
  assign last_line_len    = last_line_q;
  assign last_frame_lines = last_frame_q;

endmodule

// File: tb/tb_vga_timing_checker.sv
// Bench for vga_timing_checker: one active-high and one active-low instance share the same
// timing, so both must report identical results. Reduced timing keeps frames short.
module tb_vga_timing_checker;
  localparam int HT  = 40;
  localparam int VT  = 12;
  localparam int HSW = 6;
  localparam int VSW = 3;
  localparam int CW  = 8;

  typedef struct {
    int lines; int vsw; int bad_line; int bad_len; int hsw_line; int bad_hsw;
  } frame_t;
  typedef struct {
    logic [3:0] err; int err_cnt; bit lock_a; bit locked; int last_line; int last_frame;
  } exp_t;
  typedef struct { frame_t fa; frame_t fb; exp_t e; } vec_t;

  logic pclk = 1'b0;
  logic rst_n, en, hs, vs, hs_inv, vs_inv;
  assign hs_inv = ~hs;
  assign vs_inv = ~vs;

  logic locked_p, done_p, locked_n, done_n;
  logic [7:0] frame_cnt_p, err_cnt_p, frame_cnt_n, err_cnt_n;
  logic [3:0] err_p, err_n;
  logic [CW-1:0] ll_p, lf_p, ll_n, lf_n;

  int compared = 0;
  int mismatched = 0;

  always #5 pclk = ~pclk;

  vga_timing_checker #(.H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_W(HSW), .V_SYNC_W(VSW),
                       .SYNC_POL(1'b1), .N_FRAMES(2), .CNT_W(CW)) dut_p (
    .pclk(pclk), .rst_n(rst_n), .en(en), .hs(hs), .vs(vs), .locked(locked_p), .done(done_p),
    .frame_cnt(frame_cnt_p), .err(err_p), .err_cnt(err_cnt_p), .last_line_len(ll_p),
    .last_frame_lines(lf_p));

  vga_timing_checker #(.H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_W(HSW), .V_SYNC_W(VSW),
                       .SYNC_POL(1'b0), .N_FRAMES(2), .CNT_W(CW)) dut_n (
    .pclk(pclk), .rst_n(rst_n), .en(en), .hs(hs_inv), .vs(vs_inv), .locked(locked_n),
    .done(done_n), .frame_cnt(frame_cnt_n), .err(err_n), .err_cnt(err_cnt_n),
    .last_line_len(ll_n), .last_frame_lines(lf_n));

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic frame_t mk(int lines, int vsw, int bl, int blen, int hl, int hw);
    frame_t f;
    f.lines = lines; f.vsw = vsw; f.bad_line = bl; f.bad_len = blen;
    f.hsw_line = hl; f.bad_hsw = hw;
    return f;
  endfunction

  function automatic frame_t nom();
    return mk(VT, VSW, -1, HT, -1, HSW);
  endfunction

  function automatic exp_t mke(logic [3:0] e, int c, bit la, bit lk, int ll, int lf);
    exp_t x;
    x.err = e; x.err_cnt = c; x.lock_a = la; x.locked = lk; x.last_line = ll; x.last_frame = lf;
    return x;
  endfunction

  function automatic int line_len(frame_t f, int i);
    return (i == f.bad_line) ? f.bad_len : HT;
  endfunction

  function automatic int line_hsw(frame_t f, int i);
    return (i == f.hsw_line) ? f.bad_hsw : HSW;
  endfunction

  // Reference: first frame's first line period is not measurable (measurement starts on its
  // opening edge); every other line, every hs pulse, both frame heights and vs widths are checked.
  function automatic exp_t model(frame_t fa, frame_t fb);
    exp_t x;
    frame_t f;
    int n;
    x.err = 4'b0; x.err_cnt = 0; x.lock_a = 1'b0; x.locked = 1'b0;
    for (int fr = 0; fr < 2; fr++) begin
      f = (fr == 0) ? fa : fb;
      n = 0;
      for (int i = 0; i < f.lines; i++) begin
        if (!(fr == 0 && i == 0) && line_len(f, i) != HT) begin x.err[0] = 1'b1; n++; end
        if (line_hsw(f, i) != HSW) begin x.err[1] = 1'b1; n++; end
      end
      if (f.lines != VT) begin x.err[2] = 1'b1; n++; end
      if (f.vsw != VSW) begin x.err[3] = 1'b1; n++; end
      if (fr == 0) x.lock_a = (n == 0); else x.locked = (n == 0);
      x.err_cnt += n;
    end
    if (x.err_cnt > 255) x.err_cnt = 255;
    x.last_line = line_len(fb, fb.lines - 1);
    x.last_frame = fb.lines;
    return x;
  endfunction

  function automatic frame_t rnd_frame();
    frame_t f;
    int r;
    r = int'($urandom_range(0, 5));
    f.lines = (r == 0) ? VT - 1 : (r == 1) ? VT + 1 : VT;
    f.vsw = int'($urandom_range(2, 4));
    f.bad_line = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, VT - 2)) : -1;
    f.bad_len = ($urandom_range(0, 1) == 1) ? HT + 1 : HT - 2;
    f.hsw_line = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, VT - 2)) : -1;
    f.bad_hsw = ($urandom_range(0, 1) == 1) ? HSW + 2 : HSW - 2;
    return f;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      hs = 1'b0; vs = 1'b0;
    end
  endtask

  // One line, cycle by cycle; locked is sampled after the opening cycles of the line.
  task automatic run_line(input int len, input int hsw, input bit vlev, input int drop,
                          input logic [3:0] hold_err, output bit lk_p, output bit lk_n);
    lk_p = 1'b0; lk_n = 1'b0;
    for (int c = 0; c < len; c++) begin
      @(posedge pclk); #1;
      if (c == 2) begin lk_p = locked_p; lk_n = locked_n; end
      if (drop >= 0 && c == drop) en = 1'b0;
      if (drop >= 0 && c == drop + 1) begin
        en = 1'b1;
        chk("drop.done_p", done_p, 0);     chk("drop.done_n", done_n, 0);
        chk("drop.locked_p", locked_p, 0); chk("drop.locked_n", locked_n, 0);
        chk("drop.hold_err_p", err_p, hold_err); chk("drop.hold_err_n", err_n, hold_err);
      end
      if (drop >= 0 && c == drop + 2) begin
        chk("drop.err_p", err_p, 0);             chk("drop.err_n", err_n, 0);
        chk("drop.err_cnt_p", err_cnt_p, 0);     chk("drop.err_cnt_n", err_cnt_n, 0);
        chk("drop.frame_cnt_p", frame_cnt_p, 0); chk("drop.frame_cnt_n", frame_cnt_n, 0);
      end
      hs = (c < hsw);
      vs = vlev;
    end
  endtask

  task automatic run_frame(input frame_t f, output bit lk_p, output bit lk_n);
    bit a, b;
    lk_p = 1'b0; lk_n = 1'b0;
    for (int i = 0; i < f.lines; i++) begin
      run_line(line_len(f, i), line_hsw(f, i), (i < f.vsw), -1, 4'b0, a, b);
      if (i == 0) begin lk_p = a; lk_n = b; end
    end
  endtask

  task automatic compare_final(input string tag, input exp_t e, input bit la_p, input bit la_n);
    chk({tag, ".err_p"}, err_p, e.err);              chk({tag, ".err_n"}, err_n, e.err);
    chk({tag, ".err_cnt_p"}, err_cnt_p, e.err_cnt);  chk({tag, ".err_cnt_n"}, err_cnt_n, e.err_cnt);
    chk({tag, ".lock_a_p"}, la_p, e.lock_a);         chk({tag, ".lock_a_n"}, la_n, e.lock_a);
    chk({tag, ".locked_p"}, locked_p, e.locked);     chk({tag, ".locked_n"}, locked_n, e.locked);
    chk({tag, ".done_p"}, done_p, 1);                chk({tag, ".done_n"}, done_n, 1);
    chk({tag, ".frame_cnt_p"}, frame_cnt_p, 2);      chk({tag, ".frame_cnt_n"}, frame_cnt_n, 2);
    chk({tag, ".line_len_p"}, ll_p, e.last_line);    chk({tag, ".line_len_n"}, ll_n, e.last_line);
    chk({tag, ".frame_lines_p"}, lf_p, e.last_frame);
    chk({tag, ".frame_lines_n"}, lf_n, e.last_frame);
  endtask

  task automatic arm();
    en = 1'b0; idle(3);
    chk("idle.done_p", done_p, 0);     chk("idle.done_n", done_n, 0);
    chk("idle.locked_p", locked_p, 0); chk("idle.locked_n", locked_n, 0);
    en = 1'b1; idle(3);
    chk("seek.err_p", err_p, 0);             chk("seek.err_n", err_n, 0);
    chk("seek.err_cnt_p", err_cnt_p, 0);     chk("seek.err_cnt_n", err_cnt_n, 0);
    chk("seek.frame_cnt_p", frame_cnt_p, 0); chk("seek.frame_cnt_n", frame_cnt_n, 0);
  endtask

  task automatic run_scenario(input string tag, input frame_t fa, input frame_t fb,
                              input exp_t e);
    bit la_p, la_n, d0, d1;
    arm();
    run_frame(fa, d0, d1);
    run_frame(fb, la_p, la_n);
    run_frame(nom(), d0, d1);
    idle(3);
    compare_final(tag, e, la_p, la_n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".locked_p"}, locked_p, 0);   chk({tag, ".locked_n"}, locked_n, 0);
    chk({tag, ".done_p"}, done_p, 0);       chk({tag, ".done_n"}, done_n, 0);
    chk({tag, ".frame_cnt_p"}, frame_cnt_p, 0); chk({tag, ".frame_cnt_n"}, frame_cnt_n, 0);
    chk({tag, ".err_p"}, err_p, 0);         chk({tag, ".err_n"}, err_n, 0);
    chk({tag, ".err_cnt_p"}, err_cnt_p, 0); chk({tag, ".err_cnt_n"}, err_cnt_n, 0);
    chk({tag, ".line_len_p"}, ll_p, 0);     chk({tag, ".line_len_n"}, ll_n, 0);
    chk({tag, ".frame_lines_p"}, lf_p, 0);  chk({tag, ".frame_lines_n"}, lf_n, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    frame_t fa, fb;
    exp_t e;
    bit a, b, la_p, la_n;

    vecs[0].fa = nom(); vecs[0].fb = nom();
    vecs[0].e  = mke(4'b0000, 0, 1'b1, 1'b1, HT, VT);
    vecs[1].fa = mk(VT, VSW, 5, HT - 1, -1, HSW); vecs[1].fb = nom();
    vecs[1].e  = mke(4'b0001, 1, 1'b0, 1'b1, HT, VT);
    vecs[2].fa = mk(VT, VSW - 1, -1, HT, 4, HSW - 1); vecs[2].fb = nom();
    vecs[2].e  = mke(4'b1010, 2, 1'b0, 1'b1, HT, VT);
    vecs[3].fa = nom(); vecs[3].fb = mk(VT - 1, VSW, -1, HT, -1, HSW);
    vecs[3].e  = mke(4'b0100, 1, 1'b1, 1'b0, HT, VT - 1);
    vecs[4].fa = nom(); vecs[4].fb = mk(VT, VSW, VT - 1, HT + 2, -1, HSW);
    vecs[4].e  = mke(4'b0001, 1, 1'b1, 1'b0, HT + 2, VT);
    vecs[5].fa = mk(VT, VSW, 0, HT - 10, -1, HSW); vecs[5].fb = nom();
    vecs[5].e  = mke(4'b0000, 0, 1'b1, 1'b1, HT, VT);
    vecs[6].fa = mk(VT, VSW + 1, VSW, HT + 1, -1, HSW); vecs[6].fb = nom();
    vecs[6].e  = mke(4'b1001, 2, 1'b0, 1'b1, HT, VT);

    rst_n = 1'b0; en = 1'b0; hs = 1'b0; vs = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_scenario($sformatf("vec%0d", i), vecs[i].fa, vecs[i].fb,
                                             vecs[i].e);

    for (int i = 0; i < 6; i++) begin
      fa = rnd_frame();
      fb = rnd_frame();
      e = model(fa, fb);
      run_scenario($sformatf("rnd%0d", i), fa, fb, e);
    end

    // Reset pulse mid-measurement, then a fresh seek and two clean frames.
    arm();
    run_frame(mk(VT, VSW, 5, HT - 1, -1, HSW), a, b);
    for (int i = 0; i < 6; i++) run_line(HT, HSW, 1'b0, -1, 4'b0, a, b);
    chk("prerst.err_cnt_p", err_cnt_p, 1);
    chk("prerst.err_cnt_n", err_cnt_n, 1);
    @(posedge pclk); #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rstpulse");
    @(posedge pclk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) run_line(HT, HSW, 1'b0, -1, 4'b0, a, b);
    run_frame(nom(), a, b);
    run_frame(nom(), la_p, la_n);
    run_frame(nom(), a, b);
    idle(3);
    compare_final("rstseq", mke(4'b0000, 0, 1'b1, 1'b1, HT, VT), la_p, la_n);

    // en dropped for one cycle mid-frame: idle, then re-arm clears the record.
    arm();
    run_frame(mk(VT, VSW, 5, HT - 1, -1, HSW), a, b);
    for (int i = 0; i < 3; i++) run_line(HT, HSW, (i < VSW), -1, 4'b0, a, b);
    chk("predrop.frame_cnt_p", frame_cnt_p, 1);
    chk("predrop.frame_cnt_n", frame_cnt_n, 1);
    run_line(HT, HSW, 1'b0, 10, 4'b0001, a, b);
    for (int i = 4; i < VT; i++) run_line(HT, HSW, 1'b0, -1, 4'b0, a, b);
    run_frame(nom(), a, b);
    run_frame(nom(), la_p, la_n);
    run_frame(nom(), a, b);
    idle(3);
    compare_final("dropseq", mke(4'b0000, 0, 1'b1, 1'b1, HT, VT), la_p, la_n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
